n64_pif_si_dma: RTL and testbench
=================================

// Module: n64_pif_si_dma
// PURPOSE
//  SI-side DMA engine driving the 32-bit port (clkb side) of the PIF RAM.
//  Moves one full 64-byte PIF RAM block (16 words) per request:
//  - PIF->host: reads the block and streams it out.
//  - host->PIF: streams a block in and writes it.
//  Converts PIF byte order (byte 0 in bits 7:0) to N64 big-endian words.
// PARAMETERS
//  WORDS      16  words per transfer (power of 2, 2..16)
//  ADDR_W     4   PIF RAM word address width (2**ADDR_W >= WORDS)
//  BYTE_SWAP  1   1: host word = {B0,B1,B2,B3}, B0 = ram bits 7:0; 0: pass-through
// PORTS
//  clk          in   1       clock; same clock as PIF RAM port B
//  reset_n      in   1       asynchronous reset, active low
//  start        in   1       1-cycle request; sampled only in IDLE
//  dir          in   1       sampled with start; 0 = PIF->host (read), 1 = host->PIF (write)
//  busy         out  1       high from the cycle after an accepted start until DONE exits
//  done         out  1       1-cycle pulse at transfer end
//  ram_address  out  ADDR_W  PIF RAM port B word address
//  ram_wren     out  1       PIF RAM port B write enable
//  ram_wdata    out  32      PIF RAM port B write data
//  ram_rdata    in   32      PIF RAM port B read data; 1-cycle latency
//  rd_data      out  32      host read stream data
//  rd_valid     out  1       host read stream valid
//  rd_ready     in   1       host read stream ready
//  wr_data      in   32      host write stream data
//  wr_valid     in   1       host write stream valid
//  wr_ready     out  1       host write stream ready
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; word counter 0.
//  Async reset mid-transfer aborts immediately: no done, no further RAM writes.
//  States: IDLE, RD_ADDR, RD_LAT, RD_OUT, WR_IN, DONE.
//  IDLE:
//   - start && !dir -> RD_ADDR; start && dir -> WR_IN; counter cleared to 0.
//   - start is ignored in every other state (no queuing).
//  RD_ADDR: ram_address = counter, ram_wren = 0 -> RD_LAT.
//  RD_LAT:
//   - ram_rdata valid this cycle; register swap(ram_rdata) into rd_data.
//   - Assert rd_valid from the next cycle -> RD_OUT.
//  RD_OUT:
//   - rd_data and rd_valid hold stable until rd_valid && rd_ready.
//   - On that handshake: rd_valid drops next cycle.
//   - If counter == WORDS-1 -> DONE; else counter+1 -> RD_ADDR.
//   - Minimum 3 cycles per word.
//  WR_IN:
//   - wr_ready = 1 combinationally while in WR_IN.
//   - On wr_valid: ram_wren = 1 that same cycle, ram_address = counter,
//     ram_wdata = swap(wr_data).
//   - If counter == WORDS-1 -> DONE; else counter+1, stay in WR_IN.
//   - Sustains 1 word per clock. ram_wren is never high outside WR_IN.
//  DONE: done = 1 for exactly one cycle; busy still 1 -> IDLE.
//  Counter is ADDR_W bits. It never wraps within a transfer; ends at WORDS-1.
//  swap(x) with BYTE_SWAP=1 is {x[7:0], x[15:8], x[23:16], x[31:24]}; it is its own inverse.
//  ram_address holds its last value in IDLE. No RAM access occurs in IDLE or DONE.
//  A start in the DONE cycle is dropped. A start in the first IDLE cycle after DONE is accepted.
// TESTING
//  1 Reset: pulse reset_n low while in WR_IN at word 5
//    -> outputs 0 next edge, no done, RAM words 6..15 unchanged.
//  2 Read, rd_ready tied 1: RAM word k = 32'h03020100 + k*32'h04040404
//    -> rd_data word k = 32'h00010203 + k*32'h04040404,
//       16 beats, done once, 48 cycles start..done.
//  3 Write, wr_valid tied 1: wr_data = 32'hA0B0C0D0 ^ k
//    -> ram word k = swap(A0B0C0D0 ^ k), 16 wren cycles back to back,
//       done 1 cycle after the last.
//  4 Read backpressure: rd_ready low 7 cycles on word 3
//    -> rd_data/rd_valid stable throughout, no word skipped or duplicated.
//  5 Write bubbles: wr_valid toggled 1,0,0,1
//    -> wren only in valid cycles, addresses contiguous 0..15.
//  6 start pulsed while busy and in the DONE cycle
//    -> ignored; BYTE_SWAP=0 build passes words unchanged.

Source files
------------

// File: rtl/n64_pif_si_dma.sv
// n64_pif_si_dma
// SI-side DMA engine on the 32-bit port B of the PIF RAM. Each request moves
// one whole block of WORDS words, in one of two directions:
//   dir = 0 : PIF RAM -> host read stream  (rd_data / rd_valid / rd_ready)
//   dir = 1 : host write stream -> PIF RAM (wr_data / wr_valid / wr_ready)
// Words are converted between PIF byte order (byte 0 in bits 7:0) and N64
// big-endian order when BYTE_SWAP is 1.
// Ports:
//   clk, reset_n        clock (shared with RAM port B), async active-low reset
//   start, dir          one-cycle request and its direction, sampled in IDLE
//   busy, done          transfer in progress / one-cycle end-of-transfer pulse
//   ram_address/wren/wdata/rdata  RAM port B (read latency 1 cycle)
//   rd_data/rd_valid/rd_ready     host read stream
//   wr_data/wr_valid/wr_ready     host write stream
module n64_pif_si_dma #(
  parameter int WORDS     = 16,
  parameter int ADDR_W    = 4,
  parameter int BYTE_SWAP = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              dir,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic [31:0]       wr_data,
  input  logic              wr_valid,
  output logic              wr_ready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_LAT  = 3'd2,
    S_RD_OUT  = 3'd3,
    S_WR_IN   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_rd_valid;
  logic [31:0]         r_rd_data;
  logic                w_wr_accept;

  // Byte-order conversion; symmetric, so the same function serves both directions.
  function automatic logic [31:0] swap_bytes(input logic [31:0] x);
    logic [31:0] y;
    if (BYTE_SWAP != 0) begin
      y = {x[7:0], x[15:8], x[23:16], x[31:24]};
    end else begin
      y = x;
    end
    return y;
  endfunction

  // A host write word is taken only while in WR_IN, so the RAM is never written elsewhere.
  assign w_wr_accept = (r_state == S_WR_IN) && wr_valid;

  // The word counter doubles as the RAM address; it keeps its last value in IDLE.
  assign ram_address = r_cnt;
  assign ram_wren    = w_wr_accept;
  assign ram_wdata   = w_wr_accept ? swap_bytes(wr_data) : 32'h0000_0000;
  assign wr_ready    = (r_state == S_WR_IN);
  assign busy        = r_busy;
  assign done        = r_done;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;

  // Transfer sequencer: state, word counter and registered status/stream outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= dir ? S_WR_IN : S_RD_ADDR;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RD_ADDR: begin
          r_state <= S_RD_LAT;
        end
        S_RD_LAT: begin
          // RAM data for the address issued last cycle is valid now.
          r_rd_data  <= swap_bytes(ram_rdata);
          r_rd_valid <= 1'b1;
          r_state    <= S_RD_OUT;
        end
        S_RD_OUT: begin
          if (r_rd_valid && rd_ready) begin
            r_rd_valid <= 1'b0;
            if (r_cnt == LAST_WORD) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cnt   <= r_cnt + ADDR_W'(1);
              r_state <= S_RD_ADDR;
            end
          end else begin
            r_state <= S_RD_OUT;
          end
        end
        S_WR_IN: begin
          if (wr_valid) begin
            if (r_cnt == LAST_WORD) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cnt   <= r_cnt + ADDR_W'(1);
              r_state <= S_WR_IN;
            end
          end else begin
            r_state <= S_WR_IN;
          end
        end
        S_DONE: begin
          // A start seen here is deliberately dropped.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_rd_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n64_pif_si_dma.sv
// Scoreboard bench for n64_pif_si_dma: one BYTE_SWAP=1 instance exercised on
// reads, writes, backpressure, bubbles, dropped starts and mid-transfer reset,
// plus a BYTE_SWAP=0 instance read once. Each instance has a 1-cycle-latency
// RAM model; expected stream beats and RAM writes are queued by the stimulus
// and popped by a negedge monitor.
module tb_n64_pif_si_dma;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ld_en;

  // BYTE_SWAP = 1 instance
  logic        start1, dir1, busy1, done1, ram_wren1, rd_valid1, rd_ready1, wr_valid1, wr_ready1;
  logic [3:0]  ram_address1;
  logic [31:0] ram_wdata1, ram_rdata1, rd_data1, wr_data1;
  logic [31:0] mem1 [16];

  // BYTE_SWAP = 0 instance
  logic        start0, dir0, busy0, done0, ram_wren0, rd_valid0, rd_ready0, wr_valid0, wr_ready0;
  logic [3:0]  ram_address0;
  logic [31:0] ram_wdata0, ram_rdata0, rd_data0, wr_data0;
  logic [31:0] mem0 [16];

  int n_chk = 0;
  int n_fail = 0;
  int cyc_now = 0;
  int t_start1 = 0;
  int t_done1 = 0;
  int beats1 = 0, wrens1 = 0, done_cnt1 = 0, stalls1 = 0;
  int beats0 = 0, done_cnt0 = 0;

  logic [31:0] q_rd[$];
  int          q_wa[$];
  logic [31:0] q_wd[$];
  logic [31:0] q_rd0[$];

  n64_pif_si_dma #(.WORDS(16), .ADDR_W(4), .BYTE_SWAP(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start1), .dir(dir1),
    .busy(busy1), .done(done1), .ram_address(ram_address1), .ram_wren(ram_wren1),
    .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .rd_ready(rd_ready1), .wr_data(wr_data1),
    .wr_valid(wr_valid1), .wr_ready(wr_ready1)
  );

  n64_pif_si_dma #(.WORDS(16), .ADDR_W(4), .BYTE_SWAP(0)) dut_ns (
    .clk(clk), .reset_n(reset_n), .start(start0), .dir(dir0),
    .busy(busy0), .done(done0), .ram_address(ram_address0), .ram_wren(ram_wren0),
    .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .rd_ready(rd_ready0), .wr_data(wr_data0),
    .wr_valid(wr_valid0), .wr_ready(wr_ready0)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc_now++;
  end

  // RAM models with 1-cycle read latency and a bulk preload.
  always @(posedge clk) begin
    ram_rdata1 <= mem1[ram_address1];
    ram_rdata0 <= mem0[ram_address0];
    if (ld_en) begin
      for (int k = 0; k < 16; k++) begin
        mem1[k] <= 32'h03020100 + k * 32'h04040404;
        mem0[k] <= 32'h03020100 + k * 32'h04040404;
      end
    end else begin
      if (ram_wren1) mem1[ram_address1] <= ram_wdata1;
      if (ram_wren0) mem0[ram_address0] <= ram_wdata0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic extra(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: DUT event with nothing expected (t=%0t)", name, $time);
  endtask

  // Monitor: pops expected beats/writes whenever the DUT presents them.
  initial begin
    logic        stall_prev;
    logic [31:0] stall_data;
    stall_prev = 1'b0;
    stall_data = 32'h0;
    forever begin
      @(negedge clk);
      if (rd_valid1 && rd_ready1) begin
        if (q_rd.size() == 0) extra("rd_extra_beat");
        else chk("rd_data", rd_data1, q_rd.pop_front());
        beats1++;
      end
      if (stall_prev) begin
        chk("stall_valid", 32'(rd_valid1), 32'd1);
        chk("stall_data", rd_data1, stall_data);
      end
      stall_prev = rd_valid1 && !rd_ready1;
      stall_data = rd_data1;
      if (stall_prev) stalls1++;
      if (ram_wren1) begin
        chk("wren_needs_valid", 32'(wr_valid1), 32'd1);
        if (q_wa.size() == 0) extra("wren_extra");
        else begin
          chk("wr_addr", 32'(ram_address1), 32'(q_wa.pop_front()));
          chk("wr_data", ram_wdata1, q_wd.pop_front());
        end
        wrens1++;
      end
      if (done1) begin
        done_cnt1++;
        t_done1 = cyc_now;
      end
      if (rd_valid0 && rd_ready0) begin
        if (q_rd0.size() == 0) extra("ns_rd_extra_beat");
        else chk("ns_rd_data", rd_data0, q_rd0.pop_front());
        beats0++;
      end
      if (ram_wren0) extra("ns_wren");
      if (done0) done_cnt0++;
    end
  end

  task automatic do_start1(input logic d);
    @(posedge clk); #1;
    start1 = 1'b1;
    dir1   = d;
    @(posedge clk); #1;
    t_start1 = cyc_now;
    start1 = 1'b0;
    dir1   = 1'b0;
  endtask

  task automatic wait_done1(input int d0);
    int c = 0;
    while (done_cnt1 == d0 && c < 400) begin
      @(posedge clk); #1;
      c++;
    end
    chk("done_seen", 32'(done_cnt1 != d0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", 32'(done_cnt1 - d0), 32'd1);
  endtask

  // mode 0: valid tied high, data A0B0C0D0^k; mode 1: valid 1,0,0,1 pattern, data 12345600|k;
  // mode 2: valid tied high, data FFFF0000|k.
  task automatic wr_seq(input int mode, input int nwords);
    int k = 0;
    int c = 0;
    logic v;
    while (k < nwords && c < 200) begin
      v = (mode == 1) ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      wr_valid1 = v;
      case (mode)
        0: wr_data1 = 32'hA0B0C0D0 ^ 32'(k);
        1: wr_data1 = 32'h12345600 | 32'(k);
        default: wr_data1 = 32'hFFFF0000 | 32'(k);
      endcase
      @(posedge clk); #1;
      c++;
      if (v) k++;
    end
    wr_valid1 = 1'b0;
  endtask

  initial begin
    int d0, b0, w0, s0, c;
    reset_n = 1'b0; ld_en = 1'b0;
    start1 = 1'b0; dir1 = 1'b0; rd_ready1 = 1'b1; wr_valid1 = 1'b0; wr_data1 = 32'h0;
    start0 = 1'b0; dir0 = 1'b0; rd_ready0 = 1'b1; wr_valid0 = 1'b0; wr_data0 = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid1), 32'd0);
    chk("rst_rd_data", rd_data1, 32'h0);
    chk("rst_wren", 32'(ram_wren1), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready1), 32'd0);
    chk("rst_addr", 32'(ram_address1), 32'd0);
    chk("rst_wdata", ram_wdata1, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;

    // Read, rd_ready tied high
    for (int k = 0; k < 16; k++) q_rd.push_back(32'h00010203 + k * 32'h04040404);
    d0 = done_cnt1; b0 = beats1;
    do_start1(1'b0);
    @(negedge clk);
    chk("busy_after_start", 32'(busy1), 32'd1);
    wait_done1(d0);
    chk("rd_latency", 32'(t_done1 - t_start1), 32'd48);
    chk("rd_beats", 32'(beats1 - b0), 32'd16);
    chk("rd_q_left", 32'(q_rd.size()), 32'd0);
    chk("idle_busy", 32'(busy1), 32'd0);
    chk("idle_addr_hold", 32'(ram_address1), 32'd15);

    // Write, wr_valid tied high
    for (int k = 0; k < 16; k++) begin
      q_wa.push_back(k);
      q_wd.push_back(32'hD0C0B0A0 ^ (32'(k) << 24));
    end
    d0 = done_cnt1; w0 = wrens1;
    do_start1(1'b1);
    wr_seq(0, 16);
    wait_done1(d0);
    chk("wr_latency", 32'(t_done1 - t_start1), 32'd16);
    chk("wr_count", 32'(wrens1 - w0), 32'd16);
    chk("wr_q_left", 32'(q_wa.size()), 32'd0);
    chk("mem_w0", mem1[0], 32'hD0C0B0A0);
    chk("mem_w15", mem1[15], 32'hDFC0B0A0);

    // Read back with backpressure on word 3
    for (int k = 0; k < 16; k++) q_rd.push_back(32'hA0B0C0D0 ^ 32'(k));
    d0 = done_cnt1; b0 = beats1; s0 = stalls1;
    rd_ready1 = 1'b1;
    do_start1(1'b0);
    c = 0;
    while (beats1 - b0 < 3 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    rd_ready1 = 1'b0;
    c = 0;
    while (!rd_valid1 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (7) @(posedge clk);
    #1;
    rd_ready1 = 1'b1;
    wait_done1(d0);
    chk("bp_stall_cycles", 32'(stalls1 - s0), 32'd7);
    chk("bp_beats", 32'(beats1 - b0), 32'd16);
    chk("bp_q_left", 32'(q_rd.size()), 32'd0);

    // Write with bubbles (valid 1,0,0,1 repeating)
    for (int k = 0; k < 16; k++) begin
      q_wa.push_back(k);
      q_wd.push_back(32'h00563412 | (32'(k) << 24));
    end
    d0 = done_cnt1; w0 = wrens1;
    do_start1(1'b1);
    wr_seq(1, 16);
    wait_done1(d0);
    chk("bub_latency", 32'(t_done1 - t_start1), 32'd32);
    chk("bub_count", 32'(wrens1 - w0), 32'd16);
    chk("bub_q_left", 32'(q_wa.size()), 32'd0);

    // Start while busy and in the DONE cycle is ignored
    for (int k = 0; k < 16; k++) q_rd.push_back(32'h12345600 | 32'(k));
    d0 = done_cnt1; b0 = beats1;
    do_start1(1'b0);
    repeat (10) @(posedge clk);
    #1;
    start1 = 1'b1; dir1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; dir1 = 1'b0;
    c = 0;
    while (!done1 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("drop_busy", 32'(busy1), 32'd0);
    end
    chk("drop_done_once", 32'(done_cnt1 - d0), 32'd1);
    chk("drop_beats", 32'(beats1 - b0), 32'd16);
    chk("drop_q_left", 32'(q_rd.size()), 32'd0);

    // BYTE_SWAP = 0 instance passes words unchanged
    for (int k = 0; k < 16; k++) q_rd0.push_back(32'h03020100 + k * 32'h04040404);
    @(posedge clk); #1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    c = 0;
    while (done_cnt0 == 0 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk("ns_done", 32'(done_cnt0), 32'd1);
    chk("ns_beats", 32'(beats0), 32'd16);
    chk("ns_q_left", 32'(q_rd0.size()), 32'd0);

    // Async reset while writing word 5
    for (int k = 0; k < 5; k++) begin
      q_wa.push_back(k);
      q_wd.push_back(32'h0000FFFF | (32'(k) << 24));
    end
    d0 = done_cnt1; w0 = wrens1;
    do_start1(1'b1);
    wr_seq(2, 5);
    wr_valid1 = 1'b1;
    wr_data1  = 32'hFFFF0005;
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("ar_busy", 32'(busy1), 32'd0);
    chk("ar_wren", 32'(ram_wren1), 32'd0);
    chk("ar_wr_ready", 32'(wr_ready1), 32'd0);
    chk("ar_addr", 32'(ram_address1), 32'd0);
    chk("ar_wdata", ram_wdata1, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    wr_valid1 = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("ar_no_done", 32'(done_cnt1 - d0), 32'd0);
    chk("ar_wr_count", 32'(wrens1 - w0), 32'd5);
    chk("ar_wr_q_left", 32'(q_wa.size()), 32'd0);
    chk("ar_mem4", mem1[4], 32'h0400FFFF);
    for (int k = 5; k < 16; k++) chk("ar_mem_kept", mem1[k], 32'h00563412 | (32'(k) << 24));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
